// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   fetch_state_e     : fetch FSM state encoding
//   INSTR_NOP         : word presented to decode when no valid fetch is held
//                       (addi x0, x0, 0)
//   DEFAULT_RESET_PC  : default PC loaded on reset
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_VALID = 3'd3,
    ST_TRAP  = 3'd4
  } fetch_state_e;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Instruction memory request/response bus.
//   imem_req    : fetch request, one-cycle pulse   (fetch unit -> memory)
//   imem_addr   : fetch address                    (fetch unit -> memory)
//   imem_rvalid : read data valid                  (memory -> fetch unit)
//   imem_rdata  : fetched instruction word         (memory -> fetch unit)
// Modports: master = fetch unit side, slave = memory side.
// ---------------------------------------------------------------------------
interface instr_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/pc_next_gen.sv
// ---------------------------------------------------------------------------
// pc_next_gen
// Combinational next-PC selection for a retiring instruction.
//   pc_i         : current PC
//   taken_i      : branch/jump taken
//   target_i     : taken target from the ALU
//   next_pc_o    : PC of the next instruction (modulo 2^32)
//   misaligned_o : selected target has bit[1] set after bit[0] clearing
// Build option PC_MISALIGN_TRAP_EN: when defined the selected PC is passed
// through unmasked (the caller traps on misaligned_o); otherwise bits[1:0]
// are forced to zero.
// ---------------------------------------------------------------------------
module pc_next_gen (
  input  logic [31:0] pc_i,
  input  logic        taken_i,
  input  logic [31:0] target_i,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);

  logic [31:0] seq_pc;
  logic [31:0] sel_pc;
  logic        unused_bits;

  assign seq_pc = pc_i + 32'd4;   // wraps naturally at 2^32

  // JALR-style target: bit 0 is always cleared.
  assign sel_pc = taken_i ? {target_i[31:1], 1'b0} : seq_pc;

  assign misaligned_o = sel_pc[1];

`ifdef PC_MISALIGN_TRAP_EN
  assign next_pc_o = sel_pc;
`else
  assign next_pc_o = {sel_pc[31:2], 2'b00};
`endif

  // Bit 0 of the target never reaches the PC.
  assign unused_bits = ^{target_i[0], sel_pc[0]};

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Single-outstanding instruction fetch unit: requests the word at pc, waits
// for the memory response, holds it for the core until retire, then advances
// pc (sequential or taken target).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   imem         : instruction memory bus (instr_fetch_if.master)
//   Instruct     : instruction to decode (NOP when instr_valid=0)
//   instr_valid  : Instruct holds a valid fetched word
//   core_ready   : core retires the current instruction this cycle
//   MuxD_sel     : branch/jump taken
//   alu_target   : taken target
//   pc, pc_plus4 : current PC and PC+4 link value
//   trap         : sticky misaligned-target trap
// Parameter RESET_PC: PC loaded on reset.
// Build option PC_MISALIGN_TRAP_EN: enables the misaligned-target trap; when
// undefined, next PC is word-aligned by masking and trap is tied low.
// ---------------------------------------------------------------------------
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master imem,
  output logic [31:0]   Instruct,
  output logic          instr_valid,
  input  logic          core_ready,
  input  logic          MuxD_sel,
  input  logic [31:0]   alu_target,
  output logic [31:0]   pc,
  output logic [31:0]   pc_plus4,
  output logic          trap
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  next_pc;
  logic         misaligned;

  pc_next_gen u_pc_next_gen (
    .pc_i         (pc_q),
    .taken_i      (MuxD_sel),
    .target_i     (alu_target),
    .next_pc_o    (next_pc),
    .misaligned_o (misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= INSTR_NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      ST_IDLE:  state_d = ST_REQ;
      ST_REQ:   state_d = ST_WAIT;
      ST_WAIT: begin
        // Response is only accepted here; rvalid in any other state is stale.
        if (imem.imem_rvalid) begin
          instr_d = imem.imem_rdata;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (core_ready) begin
`ifdef PC_MISALIGN_TRAP_EN
          if (misaligned) begin
            state_d = ST_TRAP;  // pc keeps the faulting instruction's address
          end else begin
            pc_d    = next_pc;
            state_d = ST_REQ;
          end
`else
          pc_d    = next_pc;
          state_d = ST_REQ;
`endif
        end
      end
      ST_TRAP:  state_d = ST_TRAP;  // held until reset
      default:  state_d = ST_IDLE;
    endcase
  end

  assign imem.imem_req  = (state_q == ST_REQ);
  assign imem.imem_addr = pc_q;
  assign instr_valid    = (state_q == ST_VALID);
  assign Instruct       = instr_valid ? instr_q : INSTR_NOP;
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;

`ifdef PC_MISALIGN_TRAP_EN
  assign trap = (state_q == ST_TRAP);
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch. A behavioural model tracks the
// expected PC stream; memory contents are a salted hash of the address.
// Build option PC_MISALIGN_TRAP_EN selects the expected misalignment rule.
// ---------------------------------------------------------------------------
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_ready;
  logic        MuxD_sel;
  logic [31:0] alu_target;
  logic [31:0] Instruct;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        trap;

  instr_fetch_if imem_bus ();

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem_bus),
    .Instruct    (Instruct),
    .instr_valid (instr_valid),
    .core_ready  (core_ready),
    .MuxD_sel    (MuxD_sel),
    .alu_target  (alu_target),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .trap        (trap)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          req_wait;
  logic [31:0] model_pc;
  logic        model_trapped;
  logic [31:0] salt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ salt;
  endfunction

  // Architectural rule for the PC after a retire.
  task automatic model_retire(input logic taken, input logic [31:0] tgt);
    logic [31:0] nxt;
    nxt = taken ? (tgt & 32'hFFFF_FFFE) : model_pc + 32'd4;
`ifdef PC_MISALIGN_TRAP_EN
    if (nxt[1]) model_trapped = 1'b1;
    else        model_pc      = nxt;
`else
    model_pc = nxt & 32'hFFFF_FFFC;
`endif
  endtask

  // One full fetch/retire transaction. Entered at a negedge; returns at the
  // negedge on which the retire inputs are applied.
  task automatic run_instr(input int lat, input int stall, input logic taken,
                           input logic [31:0] tgt);
    logic [31:0] word;
    word     = mem_word(model_pc);
    req_wait = 0;
    do begin
      @(negedge clk);
      req_wait++;
    end while (imem_bus.imem_req !== 1'b1 && req_wait < 20);
    n_checks++;
    if (imem_bus.imem_req !== 1'b1 || req_wait != 1) begin
      $display("FAIL req_timing: req=%b after %0d cycles, required req=1 after 1 cycle",
               imem_bus.imem_req, req_wait);
      n_fail++;
      if (imem_bus.imem_req !== 1'b1) return;
    end
    n_checks++;
    if (imem_bus.imem_addr !== model_pc || pc !== model_pc) begin
      $display("FAIL fetch_addr: addr=%h pc=%h, required %h", imem_bus.imem_addr, pc, model_pc);
      n_fail++;
    end
    n_checks++;
    if (pc_plus4 !== model_pc + 32'd4) begin
      $display("FAIL pc_plus4: got %h, required %h", pc_plus4, model_pc + 32'd4);
      n_fail++;
    end
    n_checks++;
    if ({instr_valid, Instruct, trap} !== {1'b0, INSTR_NOP, 1'b0}) begin
      $display("FAIL req_outputs: valid=%b instr=%h trap=%b, required 0/%h/0",
               instr_valid, Instruct, trap, INSTR_NOP);
      n_fail++;
    end
    // Noise that must be ignored outside WAIT/VALID.
    imem_bus.imem_rvalid = 1'b1;
    imem_bus.imem_rdata  = ~word;
    core_ready = 1'($urandom);
    MuxD_sel   = 1'($urandom);
    alu_target = $urandom;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      n_checks++;
      if ({imem_bus.imem_req, instr_valid} !== 2'b00) begin
        $display("FAIL wait_outputs: req=%b valid=%b, required 0/0",
                 imem_bus.imem_req, instr_valid);
        n_fail++;
      end
      imem_bus.imem_rvalid = (k == lat);
      imem_bus.imem_rdata  = (k == lat) ? word : $urandom;
    end
    @(negedge clk);
    n_checks++;
    if ({instr_valid, Instruct} !== {1'b1, word} || pc !== model_pc) begin
      $display("FAIL valid_word: valid=%b instr=%h pc=%h, required 1/%h/%h",
               instr_valid, Instruct, pc, word, model_pc);
      n_fail++;
    end
    for (int s = 0; s < stall; s++) begin
      core_ready = 1'b0;
      MuxD_sel   = 1'($urandom);
      alu_target = $urandom;
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = $urandom;
      @(negedge clk);
      n_checks++;
      if ({imem_bus.imem_req, instr_valid, Instruct} !== {1'b0, 1'b1, word}) begin
        $display("FAIL stall_hold: req=%b valid=%b instr=%h, required 0/1/%h",
                 imem_bus.imem_req, instr_valid, Instruct, word);
        n_fail++;
      end
    end
    core_ready = 1'b1;
    MuxD_sel   = taken;
    alu_target = tgt;
    imem_bus.imem_rvalid = 1'b0;
    $display("[TB] fetch addr=%h word=%h lat=%0d stall=%0d taken=%b tgt=%h",
             model_pc, word, lat, stall, taken, tgt);
    model_retire(taken, tgt);
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    core_ready = 1'b0;
    MuxD_sel   = 1'b0;
    alu_target = '0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({imem_bus.imem_req, instr_valid, Instruct, trap} !== {1'b0, 1'b0, INSTR_NOP, 1'b0}) begin
      $display("FAIL reset_outputs: req=%b valid=%b instr=%h trap=%b, required 0/0/%h/0",
               imem_bus.imem_req, instr_valid, Instruct, trap, INSTR_NOP);
      n_fail++;
    end
    n_checks++;
    if (pc !== RESET_PC || pc_plus4 !== RESET_PC + 32'd4) begin
      $display("FAIL reset_pc: pc=%h pc_plus4=%h, required %h/%h",
               pc, pc_plus4, RESET_PC, RESET_PC + 32'd4);
      n_fail++;
    end
    model_pc      = RESET_PC;
    model_trapped = 1'b0;
    rst_n         = 1'b1;
  endtask

  task automatic test_startup();
    run_instr(1, 0, 1'b0, 32'h0);
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 8; i++) run_instr(1, 0, 1'b0, 32'h0);
  endtask

  task automatic test_branch();
    run_instr(1, 0, 1'b1, 32'h0000_0101);
    run_instr(1, 0, 1'b0, 32'h0);   // must fetch 0x100
  endtask

  task automatic test_stall();
    run_instr(1, 5, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_instr(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                1'($urandom), $urandom & 32'hFFFF_FFFD);
  endtask

  task automatic test_wrap();
    run_instr(1, 0, 1'b1, 32'hFFFF_FFFC);
    run_instr(2, 0, 1'b0, 32'h0);   // pc=FFFF_FFFC, pc_plus4 wraps to 0
    run_instr(1, 0, 1'b0, 32'h0);   // fetch at 0
  endtask

  task automatic test_reset_in_wait();
    int waited;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (imem_bus.imem_req !== 1'b1 && waited < 20);
    imem_bus.imem_rvalid = 1'b0;
    @(negedge clk);   // now waiting for the response
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({imem_bus.imem_req, instr_valid, trap} !== 3'b000 || pc !== RESET_PC ||
        Instruct !== INSTR_NOP) begin
      $display("FAIL async_reset: req=%b valid=%b trap=%b pc=%h instr=%h, required 0/0/0/%h/%h",
               imem_bus.imem_req, instr_valid, trap, pc, Instruct, RESET_PC, INSTR_NOP);
      n_fail++;
    end
    @(negedge clk);
    imem_bus.imem_rvalid = 1'b1;   // late response to the abandoned fetch
    imem_bus.imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n    = 1'b1;
    model_pc = RESET_PC;
    run_instr(1, 0, 1'b0, 32'h0);
  endtask

  task automatic test_misalign();
    logic [31:0] held_pc;
    run_instr(1, 0, 1'b1, 32'h0000_0106);
    if (model_trapped) begin
      held_pc    = model_pc;
      core_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        core_ready = 1'($urandom);
        MuxD_sel   = 1'($urandom);
        n_checks++;
        if ({trap, imem_bus.imem_req} !== 2'b10 || pc !== held_pc) begin
          $display("FAIL trap_hold: trap=%b req=%b pc=%h, required 1/0/%h",
                   trap, imem_bus.imem_req, pc, held_pc);
          n_fail++;
        end
      end
    end else begin
      run_instr(1, 0, 1'b0, 32'h0);   // must fetch 0x104
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    salt = $urandom;
    test_reset();
    test_startup();
    test_sequential();
    test_branch();
    test_stall();
    test_random();
    test_wrap();
    test_reset_in_wait();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
